// File: rtl/mem_req_demux.sv
// Routes one CPU memory request at a time to the data RAM (target 0) or the
// memory-mapped I/O block (target 1) and returns a single response pulse.
module mem_req_demux #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   IO_BASE  = 32'hFFFF_0000,
  parameter int              TIMEOUT  = 16,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          t0_valid,
  input  logic          t0_ready,
  output logic          t0_we,
  output logic [AW-1:0] t0_addr,
  output logic [DW-1:0] t0_wdata,
  input  logic          t0_done,
  input  logic [DW-1:0] t0_rdata,
  output logic          t1_valid,
  input  logic          t1_ready,
  output logic          t1_we,
  output logic [AW-1:0] t1_addr,
  output logic [DW-1:0] t1_wdata,
  input  logic          t1_done,
  input  logic [DW-1:0] t1_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  // Write accesses return zero data regardless of what the target drives.
  function automatic logic [DW-1:0] resp_data_f(input logic we, input logic [DW-1:0] rdata);
    return we ? '0 : rdata;
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          rdy_p0;
  logic          sel_p1;
  logic          we_p1;
  logic [AW-1:0] addr_p1;
  logic [DW-1:0] wdata_p1;
  logic          t0_vld_p1;
  logic          t1_vld_p1;
  logic          vld_p2;
  logic [DW-1:0] rdata_p2;
  logic          err_p2;

  logic          sel_in;
  logic          tsel_ready;
  logic          tsel_done;
  logic [DW-1:0] tsel_rdata;

  assign sel_in     = (req_addr >= IO_BASE);
  assign tsel_ready = sel_p1 ? t1_ready : t0_ready;
  assign tsel_done  = sel_p1 ? t1_done  : t0_done;
  assign tsel_rdata = sel_p1 ? t1_rdata : t0_rdata;

  // Accept -> issue -> wait -> respond; reset clears every output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdy_p0    <= 1'b0;
      sel_p1    <= 1'b0;
      we_p1     <= 1'b0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
      t0_vld_p1 <= 1'b0;
      t1_vld_p1 <= 1'b0;
      vld_p2    <= 1'b0;
      rdata_p2  <= '0;
      err_p2    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && rdy_p0) begin
            sel_p1    <= sel_in;
            we_p1     <= req_we;
            addr_p1   <= req_addr;
            wdata_p1  <= req_wdata;
            t0_vld_p1 <= !sel_in;
            t1_vld_p1 <= sel_in;
            rdy_p0    <= 1'b0;
            state     <= ISSUE;
          end else begin
            rdy_p0 <= 1'b1;
          end
        end
        ISSUE: begin
          if (tsel_ready) begin
            t0_vld_p1 <= 1'b0;
            t1_vld_p1 <= 1'b0;
            cnt       <= '0;
            if (tsel_done) begin
              rdata_p2 <= resp_data_f(we_p1, tsel_rdata);
              err_p2   <= 1'b0;
              vld_p2   <= 1'b1;
              state    <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // A done arriving on the expiry cycle still counts as success.
          if (tsel_done) begin
            rdata_p2 <= resp_data_f(we_p1, tsel_rdata);
            err_p2   <= 1'b0;
            vld_p2   <= 1'b1;
            state    <= RESP;
          end else if (cnt == CNT_MAX) begin
            rdata_p2 <= ERR_DATA;
            err_p2   <= 1'b1;
            vld_p2   <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          vld_p2   <= 1'b0;
          rdata_p2 <= '0;
          err_p2   <= 1'b0;
          rdy_p0   <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = rdy_p0;
  assign resp_valid = vld_p2;
  assign resp_rdata = rdata_p2;
  assign resp_err   = err_p2;
  assign t0_valid   = t0_vld_p1;
  assign t1_valid   = t1_vld_p1;
  assign t0_we      = we_p1;
  assign t1_we      = we_p1;
  assign t0_addr    = addr_p1;
  assign t1_addr    = addr_p1;
  assign t0_wdata   = wdata_p1;
  assign t1_wdata   = wdata_p1;

endmodule

// File: tb/tb_mem_req_demux.sv
// Directed bench for mem_req_demux: decode, latency, handshakes, timeout and reset abort.
module tb_mem_req_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        t0_valid, t0_ready, t0_we, t0_done;
  logic [31:0] t0_addr, t0_wdata, t0_rdata;
  logic        t1_valid, t1_ready, t1_we, t1_done;
  logic [31:0] t1_addr, t1_wdata, t1_rdata;

  int nvec = 0;
  int nerr = 0;
  int t1_hi = 0;
  int resp_hi = 0;
  int snap;

  mem_req_demux dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .t0_valid(t0_valid), .t0_ready(t0_ready), .t0_we(t0_we), .t0_addr(t0_addr),
    .t0_wdata(t0_wdata), .t0_done(t0_done), .t0_rdata(t0_rdata),
    .t1_valid(t1_valid), .t1_ready(t1_ready), .t1_we(t1_we), .t1_addr(t1_addr),
    .t1_wdata(t1_wdata), .t1_done(t1_done), .t1_rdata(t1_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (t1_valid === 1'b1) t1_hi++;
    if (resp_valid === 1'b1) resp_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tgt();
    t0_ready = 0; t0_done = 0; t0_rdata = '0;
    t1_ready = 0; t1_done = 0; t1_rdata = '0;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 0; req_we = 0; req_addr = 32'h0BAD_0BAD; req_wdata = 32'h0;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    clear_tgt();
    step(); step();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_t_valid", {30'b0, t1_valid, t0_valid}, 32'd0);
    rst = 0;
    step();
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Read from RAM, done two cycles after the ready handshake
    snap = t1_hi;
    t0_ready = 1;
    request(1'b0, 32'h0000_0010, 32'h0);
    chk("rd_t0_valid", {31'b0, t0_valid}, 32'd1);
    chk("rd_t0_addr", t0_addr, 32'h0000_0010);
    chk("rd_req_ready_low", {31'b0, req_ready}, 32'd0);
    step();
    t0_ready = 0;
    chk("rd_t0_valid_drop", {31'b0, t0_valid}, 32'd0);
    step();
    t0_done = 1; t0_rdata = 32'h1234_5678;
    step();
    clear_tgt();
    chk("rd_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("rd_resp_rdata", resp_rdata, 32'h1234_5678);
    chk("rd_resp_err", {31'b0, resp_err}, 32'd0);
    step();
    chk("rd_resp_pulse", {31'b0, resp_valid}, 32'd0);
    chk("rd_req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("rd_t1_never", t1_hi - snap, 32'd0);

    // Write to I/O with ready held off for three cycles
    snap = t1_hi;
    request(1'b1, 32'hFFFF_0004, 32'hA5A5_A5A5);
    chk("wr_t1_valid", {31'b0, t1_valid}, 32'd1);
    chk("wr_t0_valid", {31'b0, t0_valid}, 32'd0);
    chk("wr_t1_we", {31'b0, t1_we}, 32'd1);
    step(); step();
    chk("wr_t1_addr_hold", t1_addr, 32'hFFFF_0004);
    chk("wr_t1_wdata_hold", t1_wdata, 32'hA5A5_A5A5);
    chk("wr_t1_valid_hold", {31'b0, t1_valid}, 32'd1);
    step();
    t1_ready = 1;
    step();
    t1_ready = 0;
    chk("wr_t1_valid_cycles", t1_hi - snap, 32'd4);
    t1_done = 1; t1_rdata = 32'h5555_5555;
    step();
    clear_tgt();
    chk("wr_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("wr_resp_rdata_zero", resp_rdata, 32'h0);
    chk("wr_resp_err", {31'b0, resp_err}, 32'd0);
    step();

    // Just below the I/O window, with same-cycle ready+done
    request(1'b0, 32'hFFFE_FFFC, 32'h0);
    chk("bnd_lo_t0_valid", {31'b0, t0_valid}, 32'd1);
    chk("bnd_lo_t1_valid", {31'b0, t1_valid}, 32'd0);
    t0_ready = 1; t0_done = 1; t0_rdata = 32'h0000_00FF;
    step();
    clear_tgt();
    chk("fast_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("fast_resp_rdata", resp_rdata, 32'h0000_00FF);
    step();

    // First I/O address
    request(1'b0, 32'hFFFF_0000, 32'h0);
    chk("bnd_hi_t1_valid", {31'b0, t1_valid}, 32'd1);
    chk("bnd_hi_t0_valid", {31'b0, t0_valid}, 32'd0);
    t1_ready = 1; t1_done = 1; t1_rdata = 32'h0BAD_F00D;
    step();
    clear_tgt();
    chk("bnd_hi_resp_rdata", resp_rdata, 32'h0BAD_F00D);
    step();

    // Timeout: t0 accepts but never completes; stray t1_done must be ignored
    request(1'b0, 32'h0000_0100, 32'h0);
    t0_ready = 1;
    step();
    t0_ready = 0; t1_done = 1; t1_rdata = 32'h7777_7777;
    snap = resp_hi;
    for (int i = 0; i < 15; i++) step();
    chk("to_no_early_resp", resp_hi - snap, 32'd0);
    chk("to_resp_valid_last_wait", {31'b0, resp_valid}, 32'd0);
    step();
    clear_tgt();
    chk("to_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("to_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("to_resp_err", {31'b0, resp_err}, 32'd1);
    step();

    // done on the expiry cycle wins over the timeout
    request(1'b0, 32'h0000_0104, 32'h0);
    t0_ready = 1;
    step();
    t0_ready = 0;
    for (int i = 0; i < 15; i++) step();
    t0_done = 1; t0_rdata = 32'h600D_CAFE;
    step();
    clear_tgt();
    chk("exp_done_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("exp_done_rdata", resp_rdata, 32'h600D_CAFE);
    chk("exp_done_err", {31'b0, resp_err}, 32'd0);
    step();

    // Reset while waiting aborts the access without a response
    request(1'b1, 32'h0000_0020, 32'hCAFE_0001);
    t0_ready = 1;
    step();
    t0_ready = 0;
    step(); step();
    snap = resp_hi;
    rst = 1;
    step();
    rst = 0;
    chk("rstw_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rstw_resp", {30'b0, resp_err, resp_valid}, 32'd0);
    chk("rstw_t_valid", {30'b0, t1_valid, t0_valid}, 32'd0);
    chk("rstw_t0_addr", t0_addr, 32'h0);
    chk("rstw_t0_wdata", t0_wdata, 32'h0);
    chk("rstw_t0_we", {31'b0, t0_we}, 32'd0);
    chk("rstw_resp_rdata", resp_rdata, 32'h0);
    t0_done = 1; t0_rdata = 32'h3333_3333;
    step();
    t0_done = 0;
    chk("rstw_ready_back", {31'b0, req_ready}, 32'd1);
    step();
    chk("rstw_no_resp", resp_hi - snap, 32'd0);

    // Normal transaction after the abort
    request(1'b0, 32'h0000_0044, 32'h0);
    chk("post_t0_addr", t0_addr, 32'h0000_0044);
    t0_ready = 1; t0_done = 1; t0_rdata = 32'h0000_0077;
    step();
    clear_tgt();
    chk("post_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("post_resp_rdata", resp_rdata, 32'h0000_0077);
    step();
    chk("post_ready", {31'b0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
